voxel_ray_caster: RTL and testbench

Voxel DDA ray stepper that sits directly upstream of the chunk block-lookup stage. It accepts one ray (origin voxel, direction signs, initial and per-step DDA parameters) and walks the ray voxel by voxel using Amanatides–Woo stepping. For each voxel it issues a held address/read-enable query to the chunk stage and waits for `valid`. It stops on the first non-air block, on leaving world bounds, or after `MAX_STEPS`, then returns the result over a valid/ready handshake.

---
 rtl/voxel_ray_caster_pkg.sv | 38 +++
 rtl/voxel_ray_caster_dda_axis_select.sv | 28 ++
 rtl/voxel_ray_caster.sv | 148 ++++++++++++++
 tb/tb_voxel_ray_caster.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_ray_caster_pkg.sv
// Shared voxel types: world bounds, block position/type and the ray-caster state enum.
package voxel_ray_caster_pkg;

    localparam int CHUNK_WIDTH = 80;
    localparam int COORD_W     = 8;
    localparam int WORLD_MIN   = -(CHUNK_WIDTH / 2);
    localparam int WORLD_MAX   = (CHUNK_WIDTH / 2) - 1;

    // Bounds held one bit wider than a coordinate so a +/-1 step cannot wrap.
    localparam logic signed [COORD_W:0] WORLD_MIN_C = (COORD_W + 1)'(WORLD_MIN);
    localparam logic signed [COORD_W:0] WORLD_MAX_C = (COORD_W + 1)'(WORLD_MAX);

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } BlockPos;

    typedef logic [3:0] BlockType;
    localparam BlockType BLOCK_AIR = 4'd0;

    typedef enum logic [1:0] {
        RAY_IDLE,
        RAY_QUERY,
        RAY_DONE
    } RayState;

    function automatic logic coord_in_bounds(input logic signed [COORD_W:0] c);
        return (c >= WORLD_MIN_C) && (c <= WORLD_MAX_C);
    endfunction

    function automatic logic pos_in_bounds(input BlockPos p);
        return coord_in_bounds({p.x[COORD_W-1], p.x}) &&
               coord_in_bounds({p.y[COORD_W-1], p.y}) &&
               coord_in_bounds({p.z[COORD_W-1], p.z});
    endfunction

endpackage

// File: rtl/voxel_ray_caster_dda_axis_select.sv
// Picks the DDA axis with the smallest t_max as a one-hot vector (x wins ties, then y).
// t_max packing: x in the low T_W bits, then y, then z.
module dda_axis_select #(
    parameter int T_W = 16
) (
    input  logic [3*T_W-1:0] t_max,
    output logic [2:0]       axis
);

    logic [T_W-1:0] tx, ty, tz;

    assign tx = t_max[0*T_W +: T_W];
    assign ty = t_max[1*T_W +: T_W];
    assign tz = t_max[2*T_W +: T_W];

    // Minimum search with x > y > z priority on equal values.
    always_comb begin
        axis = 3'b001;
        if ((tx <= ty) && (tx <= tz)) begin
            axis = 3'b001;
        end else if (ty <= tz) begin
            axis = 3'b010;
        end else begin
            axis = 3'b100;
        end
    end

endmodule

// File: rtl/voxel_ray_caster.sv
// Amanatides-Woo voxel ray stepper: walks one ray through the chunk store,
// querying each voxel and stopping on a solid block, world exit or step limit.
// Per-axis vectors (dir_sign, t_max, t_delta) place x in the lowest slot.
module voxel_ray_caster
    import voxel_ray_caster_pkg::*;
#(
    parameter int MAX_STEPS = 128,
    parameter int T_W       = 16,
    localparam int STEP_W   = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    output logic              ready_out,
    input  BlockPos           origin_in,
    input  logic [2:0]        dir_sign_in,
    input  logic [3*T_W-1:0]  t_max_in,
    input  logic [3*T_W-1:0]  t_delta_in,
    output BlockPos           addr_out,
    output logic              read_enable_out,
    input  BlockType          block_in,
    input  logic              block_valid_in,
    output logic              hit_valid_out,
    input  logic              hit_ready_in,
    output logic              hit_out,
    output BlockPos           hit_pos_out,
    output BlockType          hit_block_out,
    output logic [2:0]        hit_face_out,
    output logic [STEP_W-1:0] steps_out
);

    localparam logic signed [COORD_W:0] STEP_POS = (COORD_W + 1)'(1);
    localparam logic signed [COORD_W:0] STEP_NEG = '1;

    RayState             state, state_next;
    BlockPos             pos, next_pos;
    logic [2:0]          sign;
    logic [3*T_W-1:0]    t_max, t_delta, t_max_next;
    logic [STEP_W-1:0]   steps, steps_inc;
    logic [2:0]          face, sel;
    logic                hit;
    BlockType            hit_block;
    logic signed [COORD_W:0] ext_x, ext_y, ext_z;
    logic                next_in, limit, accept, air_step;

    function automatic logic [T_W-1:0] sat_add(input logic [T_W-1:0] a, input logic [T_W-1:0] b);
        logic [T_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[T_W] ? '1 : s[T_W-1:0];
    endfunction

    dda_axis_select #(.T_W(T_W)) u_axis_select (
        .t_max (t_max),
        .axis  (sel)
    );

    // Candidate next voxel, its bounds check and the advanced t_max.
    always_comb begin
        ext_x = {pos.x[COORD_W-1], pos.x};
        ext_y = {pos.y[COORD_W-1], pos.y};
        ext_z = {pos.z[COORD_W-1], pos.z};
        if (sel[0]) ext_x = ext_x + (sign[0] ? STEP_NEG : STEP_POS);
        if (sel[1]) ext_y = ext_y + (sign[1] ? STEP_NEG : STEP_POS);
        if (sel[2]) ext_z = ext_z + (sign[2] ? STEP_NEG : STEP_POS);
        next_pos.x = ext_x[COORD_W-1:0];
        next_pos.y = ext_y[COORD_W-1:0];
        next_pos.z = ext_z[COORD_W-1:0];
        next_in    = coord_in_bounds(ext_x) && coord_in_bounds(ext_y) && coord_in_bounds(ext_z);
        t_max_next = t_max;
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) t_max_next[i*T_W +: T_W] = sat_add(t_max[i*T_W +: T_W], t_delta[i*T_W +: T_W]);
        end
    end

    assign steps_inc = steps + 1'b1;
    assign limit     = (steps_inc == STEP_W'(MAX_STEPS));
    assign accept    = (state == RAY_IDLE) && start_in;
    assign air_step  = (state == RAY_QUERY) && block_valid_in && (block_in == BLOCK_AIR);

    // Next-state logic: terminate on solid block, world exit or step budget.
    always_comb begin
        state_next = state;
        case (state)
            RAY_IDLE: begin
                if (start_in) state_next = pos_in_bounds(origin_in) ? RAY_QUERY : RAY_DONE;
            end
            RAY_QUERY: begin
                if (block_valid_in && ((block_in != BLOCK_AIR) || !next_in || limit)) state_next = RAY_DONE;
            end
            RAY_DONE: begin
                if (hit_ready_in) state_next = RAY_IDLE;
            end
            default: state_next = RAY_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= RAY_IDLE;
        else           state <= state_next;
    end

    // Ray position, step count and result registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pos       <= '0;
            steps     <= '0;
            face      <= '0;
            hit       <= 1'b0;
            hit_block <= BLOCK_AIR;
        end else if (accept) begin
            pos       <= origin_in;
            steps     <= '0;
            face      <= '0;
            hit       <= 1'b0;
            hit_block <= BLOCK_AIR;
        end else if (air_step) begin
            steps <= steps_inc;
            face  <= sel;
            if (next_in && !limit) pos <= next_pos;
        end else if ((state == RAY_QUERY) && block_valid_in) begin
            hit       <= 1'b1;
            hit_block <= block_in;
        end
    end

    // Per-ray DDA parameters; only meaningful once a ray has been accepted.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            sign    <= dir_sign_in;
            t_max   <= t_max_in;
            t_delta <= t_delta_in;
        end else if (air_step) begin
            t_max <= t_max_next;
        end
    end

    assign ready_out       = (state == RAY_IDLE);
    assign read_enable_out = (state == RAY_QUERY);
    assign hit_valid_out   = (state == RAY_DONE);
    assign addr_out        = pos;
    assign hit_pos_out     = pos;
    assign hit_out         = hit;
    assign hit_block_out   = hit_block;
    assign hit_face_out    = face;
    assign steps_out       = steps;

endmodule

// File: tb/tb_voxel_ray_caster.sv
// Directed bench for voxel_ray_caster with a behavioural chunk mock of adjustable latency.
module tb_voxel_ray_caster;
    import voxel_ray_caster_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start4 = 1'b0;
    logic        ready, ready4;
    BlockPos     origin = '0;
    logic [2:0]  dsign = '0;
    logic [47:0] tmax = '0, tdelta = '0;
    BlockPos     addr, addr4, hpos, hpos4;
    logic        re, re4;
    BlockType    blk, hblk, hblk4;
    logic        blk_valid;
    logic        hv, hv4;
    logic        hready = 1'b0, hready4 = 1'b0;
    logic        hit, hit4;
    logic [2:0]  face, face4;
    logic [7:0]  steps;
    logic [2:0]  steps4;

    int checks = 0;
    int errors = 0;

    // Chunk mock state
    logic        solid_en = 1'b0;
    BlockPos     solid_pos = '0;
    BlockType    solid_type = BLOCK_AIR;
    logic        rand_lat = 1'b0;
    int          fixed_lat = 2;
    int          cur_lat = 0;
    int          wait_cnt = 0;

    // Monitors
    int          q_count = 0, oob_q = 0, re_cnt = 0, hv_cnt = 0, jumps = 0, q4 = 0;
    BlockPos     q_log [0:63];
    logic        prev_pending = 1'b0;
    BlockPos     prev_addr = '0;

    always #5 clk = ~clk;

    voxel_ray_caster dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .ready_out(ready),
        .origin_in(origin), .dir_sign_in(dsign), .t_max_in(tmax), .t_delta_in(tdelta),
        .addr_out(addr), .read_enable_out(re), .block_in(blk), .block_valid_in(blk_valid),
        .hit_valid_out(hv), .hit_ready_in(hready), .hit_out(hit), .hit_pos_out(hpos),
        .hit_block_out(hblk), .hit_face_out(face), .steps_out(steps)
    );

    voxel_ray_caster #(.MAX_STEPS(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start4), .ready_out(ready4),
        .origin_in(origin), .dir_sign_in(dsign), .t_max_in(tmax), .t_delta_in(tdelta),
        .addr_out(addr4), .read_enable_out(re4), .block_in(BLOCK_AIR), .block_valid_in(re4),
        .hit_valid_out(hv4), .hit_ready_in(hready4), .hit_out(hit4), .hit_pos_out(hpos4),
        .hit_block_out(hblk4), .hit_face_out(face4), .steps_out(steps4)
    );

    assign blk_valid = re && (wait_cnt == cur_lat);
    assign blk = (solid_en && addr == solid_pos) ? solid_type : BLOCK_AIR;

    always @(posedge clk) begin
        if (!re || blk_valid) begin
            wait_cnt <= 0;
            cur_lat  <= rand_lat ? int'($urandom_range(0, 5)) : fixed_lat;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (re && blk_valid) begin
            if (q_count < 64) q_log[q_count] <= addr;
            q_count <= q_count + 1;
        end
        if (re && addr.x == 8'sd40) oob_q <= oob_q + 1;
        if (re) re_cnt <= re_cnt + 1;
        if (hv) hv_cnt <= hv_cnt + 1;
        if (re4) q4 <= q4 + 1;
        if (prev_pending && re && (addr != prev_addr)) jumps <= jumps + 1;
        prev_pending <= re && !blk_valid;
        prev_addr    <= addr;
    end

    function automatic BlockPos mkpos(input int x, input int y, input int z);
        BlockPos p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.z = 8'(z);
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input BlockPos o, input logic [2:0] s, input logic [47:0] tm, input logic [47:0] td);
        @(negedge clk);
        origin = o; dsign = s; tmax = tm; tdelta = td;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (!hv && cycles < bound) begin
            @(posedge clk);
            #1 cycles++;
        end
        check("done_reached", hv, 1'b1);
    endtask

    task automatic consume();
        @(negedge clk);
        hready = 1'b1;
        @(posedge clk);
        #1 hready = 1'b0;
        check("consume_ready", ready, 1'b1);
        check("consume_hv_low", hv, 1'b0);
    endtask

    int lat, base, aux;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_re", re, 1'b0);
        check("rst_hv", hv, 1'b0);
        check("rst_addr", addr, 24'h0);
        check("rst_hit", hit, 1'b0);
        check("rst_hpos", hpos, 24'h0);
        check("rst_hblk", hblk, 4'h0);
        check("rst_face", face, 3'b000);
        check("rst_steps", steps, 8'd0);
        @(negedge clk) rst_n = 1'b1;

        // Straight hit along +x, 2-cycle chunk latency
        solid_en = 1'b1; solid_pos = mkpos(3, 0, 0); solid_type = 4'd3; fixed_lat = 2;
        repeat (2) @(posedge clk);
        launch(mkpos(0, 0, 0), 3'b000, {16'hFFFF, 16'hFFFF, 16'h0080}, {16'h0100, 16'h0100, 16'h0100});
        wait_done(60, lat);
        check("s_latency", lat, 12);
        check("s_hit", hit, 1'b1);
        check("s_pos", hpos, mkpos(3, 0, 0));
        check("s_blk", hblk, 4'd3);
        check("s_face", face, 3'b001);
        check("s_steps", steps, 8'd3);
        check("s_ready_busy", ready, 1'b0);
        consume();

        // Tie-break to x with negative stepping
        solid_pos = mkpos(-1, 0, 0); solid_type = 4'd2; fixed_lat = 1;
        repeat (2) @(posedge clk);
        base = q_count;
        launch(mkpos(0, 0, 0), 3'b111, {16'h0100, 16'h0100, 16'h0100}, {16'h0100, 16'h0100, 16'h0100});
        wait_done(60, lat);
        check("t_queries", q_count - base, 2);
        check("t_second_q", q_log[base + 1], mkpos(-1, 0, 0));
        check("t_hit", hit, 1'b1);
        check("t_face", face, 3'b001);
        check("t_steps", steps, 8'd1);
        consume();

        // Exit through +x world edge
        solid_en = 1'b0;
        base = q_count; aux = oob_q;
        launch(mkpos(39, 0, 0), 3'b000, {16'hFFFF, 16'hFFFF, 16'h0000}, {16'h0100, 16'h0100, 16'h0100});
        wait_done(60, lat);
        check("e_hit", hit, 1'b0);
        check("e_pos", hpos, mkpos(39, 0, 0));
        check("e_blk", hblk, BLOCK_AIR);
        check("e_steps", steps, 8'd1);
        check("e_face", face, 3'b001);
        check("e_queries", q_count - base, 1);
        check("e_no_q40", oob_q - aux, 0);
        consume();

        // Origin out of bounds: no query at all
        aux = re_cnt;
        launch(mkpos(-41, 0, 0), 3'b000, {16'h0000, 16'h0000, 16'h0000}, {16'h0100, 16'h0100, 16'h0100});
        wait_done(10, lat);
        check("o_hit", hit, 1'b0);
        check("o_steps", steps, 8'd0);
        check("o_pos", hpos, mkpos(-41, 0, 0));
        check("o_face", face, 3'b000);
        check("o_no_re", re_cnt - aux, 0);
        consume();

        // Step limit on the MAX_STEPS=4 instance
        @(negedge clk);
        origin = mkpos(0, 0, 0); dsign = 3'b000;
        tmax = {16'hFFFF, 16'hFFFF, 16'h0000}; tdelta = {16'h0001, 16'h0001, 16'h0001};
        aux = q4;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        lat = 0;
        while (!hv4 && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        check("l_done", hv4, 1'b1);
        check("l_hit", hit4, 1'b0);
        check("l_steps", steps4, 3'd4);
        check("l_pos", hpos4, mkpos(3, 0, 0));
        check("l_queries", q4 - aux, 4);
        @(negedge clk) hready4 = 1'b1;
        @(posedge clk);
        #1 hready4 = 1'b0;
        check("l_ready", ready4, 1'b1);

        // Random chunk latency on a diagonal ray, then backpressure
        solid_en = 1'b1; solid_pos = mkpos(2, 2, 2); solid_type = 4'd5; rand_lat = 1'b1;
        aux = jumps;
        launch(mkpos(0, 0, 0), 3'b000, {16'h0030, 16'h0020, 16'h0010}, {16'h0040, 16'h0040, 16'h0040});
        wait_done(200, lat);
        check("r_hit", hit, 1'b1);
        check("r_pos", hpos, mkpos(2, 2, 2));
        check("r_blk", hblk, 4'd5);
        check("r_steps", steps, 8'd6);
        check("r_face", face, 3'b100);
        check("r_addr_stable", jumps - aux, 0);
        @(negedge clk);
        origin = mkpos(5, 5, 5);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("b_hv", hv, 1'b1);
            check("b_ready", ready, 1'b0);
            check("b_pos", hpos, mkpos(2, 2, 2));
            check("b_steps", steps, 8'd6);
        end
        @(negedge clk) start = 1'b0;
        consume();
        rand_lat = 1'b0;

        // Asynchronous reset in the middle of a query
        solid_pos = mkpos(3, 0, 0); solid_type = 4'd3; fixed_lat = 5;
        repeat (2) @(posedge clk);
        launch(mkpos(0, 0, 0), 3'b000, {16'hFFFF, 16'hFFFF, 16'h0080}, {16'h0100, 16'h0100, 16'h0100});
        repeat (3) @(posedge clk);
        #1 check("m_re_before", re, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("m_re_drop", re, 1'b0);
        check("m_ready", ready, 1'b1);
        check("m_hv", hv, 1'b0);
        aux = hv_cnt;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("m_no_result", hv_cnt - aux, 0);
        fixed_lat = 2;
        repeat (2) @(posedge clk);
        launch(mkpos(0, 0, 0), 3'b000, {16'hFFFF, 16'hFFFF, 16'h0080}, {16'h0100, 16'h0100, 16'h0100});
        wait_done(60, lat);
        check("p_latency", lat, 12);
        check("p_hit", hit, 1'b1);
        check("p_pos", hpos, mkpos(3, 0, 0));
        check("p_steps", steps, 8'd3);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
